// File: rtl/alu_ctrl.sv
// alu_ctrl: operator-side controller for the lab3 8-bit ALU.
//
// Captures operand A, then operand B, from the switch bank on successive
// presses of the enter button. It then steps the ALU function code through
// add, sub and max, and wraps back to operand A entry. The sign button
// toggles signed mode, but only while an arithmetic op is selected.
//
// Ports:
//   clk    in   system clock (100 MHz)
//   rst_n  in   asynchronous active-low reset
//   sw     in   [WIDTH-1:0] switch operand value
//   enter  in   debounced enter button (level, active-high)
//   sign   in   debounced sign button (level, active-high)
//   A      out  [WIDTH-1:0] registered operand A
//   B      out  [WIDTH-1:0] registered operand B
//   FN     out  [3:0] registered ALU function code, {signed, op[2:0]}
//   upd    out  one-cycle pulse after A or B is captured
//
// Optional build macro ALU_CTRL_SYNC_EN: when defined, passes sw, enter and
// sign through two-flop synchronizers before use. This adds two edges of
// latency.

module alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             enter,
  input  logic             sign,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       FN,
  output logic             upd
);

  // State encoding doubles as the op field of FN.
  typedef enum logic [2:0] {
    ST_A   = 3'b000,
    ST_B   = 3'b001,
    ST_ADD = 3'b010,
    ST_SUB = 3'b011,
    ST_MAX = 3'b100
  } state_t;

  state_t           state, state_d;
  logic             flag, flag_d;
  logic [WIDTH-1:0] a_d, b_d;
  logic [3:0]       fn_d;
  logic [2:0]       op_d;
  logic             upd_d;
  logic             is_op_d;

  logic [WIDTH-1:0] sw_use;
  logic             enter_use, sign_use;
  logic             enter_q, sign_q;
  logic             enter_ev, sign_ev;

`ifdef ALU_CTRL_SYNC_EN
  logic [WIDTH-1:0] sw_p0, sw_p1;
  logic             enter_p0, enter_p1;
  logic             sign_p0, sign_p1;

  // Input synchronizer stages p0 -> p1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0    <= '0;
      sw_p1    <= '0;
      enter_p0 <= 1'b0;
      enter_p1 <= 1'b0;
      sign_p0  <= 1'b0;
      sign_p1  <= 1'b0;
    end else begin
      sw_p0    <= sw;
      sw_p1    <= sw_p0;
      enter_p0 <= enter;
      enter_p1 <= enter_p0;
      sign_p0  <= sign;
      sign_p1  <= sign_p0;
    end
  end

  assign sw_use    = sw_p1;
  assign enter_use = enter_p1;
  assign sign_use  = sign_p1;
`else
  assign sw_use    = sw;
  assign enter_use = enter;
  assign sign_use  = sign;
`endif

  // Button history for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      enter_q <= enter_use;
      sign_q  <= sign_use;
    end
  end

  assign enter_ev = enter_use & ~enter_q;
  assign sign_ev  = sign_use & ~sign_q;

  // Next-state / next-output logic. Enter takes priority: a sign event on
  // the same edge as an enter event is dropped.
  always_comb begin
    state_d = state;
    flag_d  = flag;
    a_d     = A;
    b_d     = B;
    upd_d   = 1'b0;
    case (state)
      ST_A: begin
        if (enter_ev) begin
          a_d     = sw_use;
          upd_d   = 1'b1;
          state_d = ST_B;
        end
      end
      ST_B: begin
        if (enter_ev) begin
          b_d     = sw_use;
          upd_d   = 1'b1;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        if (enter_ev)     state_d = ST_SUB;
        else if (sign_ev) flag_d  = ~flag;
      end
      ST_SUB: begin
        if (enter_ev)     state_d = ST_MAX;
        else if (sign_ev) flag_d  = ~flag;
      end
      ST_MAX: begin
        if (enter_ev)     state_d = ST_A;
        else if (sign_ev) flag_d  = ~flag;
      end
      default: state_d = ST_A;
    endcase

    // Signed mode starts fresh each time operand entry begins.
    if (state_d == ST_A) flag_d = 1'b0;

    is_op_d = (state_d == ST_ADD) || (state_d == ST_SUB) || (state_d == ST_MAX);
    op_d    = state_d;
    fn_d    = {is_op_d & flag_d, op_d};
  end

  // Output / state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_A;
      flag  <= 1'b0;
      A     <= '0;
      B     <= '0;
      FN    <= 4'b0000;
      upd   <= 1'b0;
    end else begin
      state <= state_d;
      flag  <= flag_d;
      A     <= a_d;
      B     <= b_d;
      FN    <= fn_d;
      upd   <= upd_d;
    end
  end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Operator-side controller that drives the 8-bit ALU's A, B and FN inputs from board switches and two push-buttons (enter, sign).
- It is the initiator of the ALU operand/opcode interface; the ALU is the combinational consumer.
- Sequences operand entry A, then B, then steps through the arithmetic operations, with a sign-mode toggle.
- Sits between the button debouncers / switch bank and the ALU instance in the lab3 top level.

Parameters:
- WIDTH, 8, operand width of sw, A and B.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  WIDTH  switch operand value.
- enter  in  1  debounced enter button, level, active-high.
- sign  in  1  debounced sign button, level, active-high.
- A  out  WIDTH  registered operand A to the ALU.
- B  out  WIDTH  registered operand B to the ALU.
- FN  out  4  registered ALU function code.
- upd  out  1  one-cycle pulse when A or B is captured.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: A=0, B=0, FN=4'b0000, upd=0, state=ST_A, signed flag=0, button history registers=0.
- Edge detect: the block registers enter_q/sign_q every cycle.
  - enter_ev = enter & ~enter_q; sign_ev = sign & ~sign_q.
  - A level held high produces exactly one event.
- Latency: an event seen at clock edge k updates state, A/B, FN and upd at that same edge k. Outputs are visible for cycle k+1.
- FN encoding: FN[3] = signed mode; FN[2:0] = op.
  - 000 pass A, 001 pass B, 010 add, 011 sub, 100 max.
- State machine (FN[2:0] per state):
  - ST_A (000): on enter_ev, A<=sw, upd=1, go to ST_B.
  - ST_B (001): on enter_ev, B<=sw, upd=1, go to ST_ADD.
  - ST_ADD (010): on enter_ev, go to ST_SUB.
  - ST_SUB (011): on enter_ev, go to ST_MAX.
  - ST_MAX (100): on enter_ev, go to ST_A (wrap-around). A and B hold their values until recaptured.
- FN[3] rules:
  - FN[3] is forced to 0 in ST_A and ST_B.
  - In the op states FN[3] = signed flag.
  - sign_ev toggles the signed flag only in ST_ADD, ST_SUB and ST_MAX; it is ignored in ST_A and ST_B.
  - The signed flag persists across op-state steps and is cleared on entry to ST_A.
- Simultaneous enter_ev and sign_ev: enter wins and the sign event is discarded, so the flag does not toggle that cycle.
- upd is high only on the cycle following a capture edge; otherwise it is 0.
- Illegal/unused state encodings recover to ST_A with FN=0000 on the next edge.
- Reset mid-sequence: all outputs return to their reset values immediately (asynchronous). The first enter after release captures A.
- sw changes outside a capture edge have no effect on A or B.

Optional Feature:
- Macro ALU_CTRL_SYNC_EN.
- When defined:
  - sw, enter and sign each pass through a two-flop synchronizer before use.
  - Event-to-output latency becomes 3 edges after the raw input rises: 2 synchronizer edges plus the update edge.
  - Synchronizer flops reset to 0.
- When undefined:
  - Inputs are used directly; latency is as stated in Behaviour.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> A=0, B=0, FN=0000, upd=0. No change with enter held low for 10 cycles.
- Operand entry: sw=8'h05 plus enter pulse -> A=05, upd one cycle, FN=0001. Then sw=8'h03 plus enter -> B=03, FN=0010.
- Held button: enter held high for 20 cycles in ST_ADD -> exactly one step to FN=0011. No further change until enter falls and rises again.
- Op cycling and wrap: from ST_ADD, three enter pulses -> FN 0011, 0100, 0000. A=05 and B=03 are retained; sw changes during ops are ignored.
- Sign mode:
  - In ST_SUB, sign pulse -> FN=1011; second sign pulse -> FN=0011.
  - Sign pulse in ST_A -> FN stays 0000.
  - Enter and sign rising on the same edge in ST_ADD (flag 0) -> FN=0011, flag unchanged.
- Async reset mid-op: rst_n dropped mid-cycle in ST_MAX with A=91, B=7C -> A, B and FN go to 0 before the next clk edge. The next enter captures sw into A.
